stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have parameter BEQ_OP, default 5'b00100, the BEQ opcode within Type 2'b10.
REQ-002 The block SHALL have parameter JAL_OP, default 5'b00001, the JAL opcode within Type 2'b01; any other Type 2'b01 opcode is J.
REQ-003 The block SHALL have parameter LW_OP, default 5'b00010, and parameter SW_OP, default 5'b00011, the load and store opcodes within Type 2'b10.
REQ-004 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port Type, input, 2, the instruction class: 00 R, 01 J, 10 I, 11 reserved.
REQ-007 The block SHALL have port OPCode, input, 5, the instruction opcode.
REQ-008 The block SHALL have port Zero, input, 1, the ALU zero flag, valid in EXEC.
REQ-009 The block SHALL have port Stop, input, 1, the halt request, sampled in DECODE.
REQ-010 The block SHALL have port imem_ready, input, 1, the instruction-fetch complete handshake.
REQ-011 The block SHALL have port dmem_ready, input, 1, the data-access complete handshake.
REQ-012 The block SHALL have port imem_req, output, 1, the instruction fetch request.
REQ-013 The block SHALL have port dmem_req, dmem_we, output, 1 each, the data request and write enable.
REQ-014 The block SHALL have port IRWrite, RegWrite, PcWrite, output, 1 each, the instruction-register, register-file and PC write strobes.
REQ-015 The block SHALL have port PcSrc, output, 2, the next-PC select: 00 hold, 01 branch target, 10 jump target, 11 PC+1.
REQ-016 The block SHALL have port state, output, 3, the current state; port halted, output, 1; port retired_count, output, 16.

Function
REQ-017 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH on the next edge.
REQ-018 FETCH SHALL assert imem_req; on imem_ready=1 it SHALL pulse IRWrite for that cycle and go to DECODE, otherwise it SHALL stay in FETCH with no timeout.
REQ-019 In DECODE with Stop=1 the FSM SHALL go to HALT with no write strobes; Stop SHALL have priority over all decode outcomes.
REQ-020 In DECODE, J SHALL assert PcWrite with PcSrc=10 and go to FETCH; all other instructions SHALL go to EXEC.
REQ-021 In EXEC, BEQ SHALL assert PcWrite with PcSrc=01 if Zero=1, else PcSrc=11, and go to FETCH.
REQ-022 In EXEC, LW and SW SHALL go to MEM; R-type, other Type 10 opcodes and JAL SHALL go to WB.
REQ-023 In EXEC, Type 11 (reserved) SHALL assert PcWrite with PcSrc=11 and go to FETCH, as a NOP.
REQ-024 MEM SHALL hold dmem_req=1, with dmem_we=1 only for SW, until dmem_ready=1.
REQ-025 When dmem_ready=1 in MEM, SW SHALL assert PcWrite with PcSrc=11 and go to FETCH; LW SHALL go to WB.
REQ-026 WB SHALL assert RegWrite and PcWrite for exactly one cycle and go to FETCH; PcSrc SHALL be 10 for JAL and 11 otherwise.
REQ-027 HALT SHALL be absorbing: PcSrc=00, all strobes 0, halted=1; it SHALL be left only by reset.
REQ-028 PcSrc SHALL be 00 in every cycle where PcWrite=0.
REQ-029 Type and OPCode SHALL be treated as stable from DECODE through retirement.
REQ-030 A ready input asserted outside its wait state SHALL be ignored.
REQ-031 Each instruction SHALL retire, with exactly one PcWrite pulse, in 2 cycles (J), 3 (BEQ/NOP), 4 (ALU/JAL/SW) or 5 (LW), plus wait cycles.

Reset
REQ-032 On a rising clk edge with reset=1 the state SHALL become FETCH, halted SHALL become 0 and retired_count SHALL become 0, regardless of current state, including mid-MEM and HALT.
REQ-033 While reset=1, every output strobe, imem_req, dmem_req and PcSrc SHALL be driven 0.

Configuration
REQ-034 With SEQ_RETIRE_CNT_EN defined, retired_count SHALL increment on each PcWrite pulse, saturate at 16'hFFFF and clear on reset.
REQ-035 Without SEQ_RETIRE_CNT_EN, retired_count SHALL be held at 16'h0000 and no counter register SHALL be built; the port list SHALL be identical in both builds.

Verification
REQ-036 Reset, then R-type (Type=00) with imem_ready=1 -> states 0,1,2,4,0; RegWrite=1 and PcWrite=1, PcSrc=11 in WB.
REQ-037 BEQ (Type=10, OPCode=00100) with Zero=1, then a second BEQ with Zero=0 -> EXEC PcSrc=01, then 11; no RegWrite.
REQ-038 LW (OPCode=00010) with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 MEM cycles, then WB RegWrite=1; SW (00011) -> dmem_we=1, no WB.
REQ-039 J (Type=01, OPCode=00000) -> PcWrite with PcSrc=10 in DECODE; JAL (00001) -> RegWrite and PcSrc=10 in WB.
REQ-040 Stop=1 in DECODE -> HALT, halted=1, PcSrc=00 for 10 cycles; reset asserted mid-MEM -> FETCH next edge, retired_count=0.
REQ-041 With SEQ_RETIRE_CNT_EN defined, 5 retired instructions -> retired_count=5; without it -> retired_count=0.

Source files
------------

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT control FSM.
// Optional retirement counter enabled by defining SEQ_RETIRE_CNT_EN.
module stage_sequencer #(
  parameter logic [4:0] BEQ_OP = 5'b00100,
  parameter logic [4:0] JAL_OP = 5'b00001,
  parameter logic [4:0] LW_OP  = 5'b00010,
  parameter logic [4:0] SW_OP  = 5'b00011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Type,
  input  logic [4:0]  OPCode,
  input  logic        Zero,
  input  logic        Stop,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        PcWrite,
  output logic [1:0]  PcSrc,
  output logic [2:0]  state,
  output logic        halted,
  output logic [15:0] retired_count
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] SRC_HOLD   = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_INC    = 2'b11;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  logic is_jal;
  logic is_j;
  logic is_beq;
  logic is_lw;
  logic is_sw;
  logic is_rsvd;

  // Instruction class decode; Type/OPCode are held stable by the datapath from DECODE on.
  always_comb begin
    is_jal  = (Type == 2'b01) && (OPCode == JAL_OP);
    is_j    = (Type == 2'b01) && (OPCode != JAL_OP);
    is_beq  = (Type == 2'b10) && (OPCode == BEQ_OP);
    is_lw   = (Type == 2'b10) && (OPCode == LW_OP);
    is_sw   = (Type == 2'b10) && (OPCode == SW_OP);
    is_rsvd = (Type == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe generation; strobes are forced low while reset is held.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    RegWrite = 1'b0;
    PcWrite  = 1'b0;
    PcSrc    = SRC_HOLD;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (Stop) begin
          state_d = S_HALT;
        end else if (is_j) begin
          PcWrite = 1'b1;
          PcSrc   = SRC_JUMP;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          PcWrite = 1'b1;
          PcSrc   = Zero ? SRC_BRANCH : SRC_INC;
          state_d = S_FETCH;
        end else if (is_rsvd) begin
          PcWrite = 1'b1;
          PcSrc   = SRC_INC;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            PcWrite = 1'b1;
            PcSrc   = SRC_INC;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PcWrite  = 1'b1;
        PcSrc    = is_jal ? SRC_JUMP : SRC_INC;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (reset) begin
      imem_req = 1'b0;
      IRWrite  = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      RegWrite = 1'b0;
      PcWrite  = 1'b0;
      PcSrc    = SRC_HOLD;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == S_HALT);

`ifdef SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;

  // One PcWrite pulse per retired instruction; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (PcWrite && (retired_q != {CNT_W{1'b1}})) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: per-cycle expected trace built from
// instruction-class rules, randomized opcodes, wait lengths and ready noise.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Type;
  logic [4:0]  OPCode;
  logic        Zero, Stop, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, IRWrite, RegWrite, PcWrite;
  logic [1:0]  PcSrc;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] retired_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_retired = 0;

`ifdef SEQ_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [4:0] OP_BEQ = 5'b00100;
  localparam logic [4:0] OP_JAL = 5'b00001;
  localparam logic [4:0] OP_LW  = 5'b00010;
  localparam logic [4:0] OP_SW  = 5'b00011;

  localparam int K_R = 0, K_I = 1, K_BEQ = 2, K_LW = 3, K_SW = 4, K_J = 5, K_JAL = 6, K_NOP = 7;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] outs;  // {halted, imem_req, IRWrite, dmem_req, dmem_we, RegWrite, PcWrite, PcSrc}
    logic       irdy;
    logic       drdy;
  } rec_t;

  rec_t q[$];

  stage_sequencer dut (
    .clk(clk), .reset(reset), .Type(Type), .OPCode(OPCode), .Zero(Zero), .Stop(Stop),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .PcWrite(PcWrite), .PcSrc(PcSrc), .state(state), .halted(halted),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] mk(input logic ireq, input logic irw, input logic dreq,
                                    input logic dwe, input logic regw, input logic pcw,
                                    input logic [1:0] src);
    return {1'b0, ireq, irw, dreq, dwe, regw, pcw, src};
  endfunction

  function automatic void push(input logic [2:0] st, input logic [8:0] outs,
                               input logic irdy, input logic drdy);
    rec_t r;
    r.st = st; r.outs = outs; r.irdy = irdy; r.drdy = drdy;
    q.push_back(r);
  endfunction

  task automatic pick(input int k, output logic [1:0] ty, output logic [4:0] op);
    case (k)
      K_R:   begin ty = 2'b00; op = 5'($urandom); end
      K_I:   begin
        ty = 2'b10;
        do op = 5'($urandom); while (op == OP_BEQ || op == OP_LW || op == OP_SW);
      end
      K_BEQ: begin ty = 2'b10; op = OP_BEQ; end
      K_LW:  begin ty = 2'b10; op = OP_LW; end
      K_SW:  begin ty = 2'b10; op = OP_SW; end
      K_J:   begin
        ty = 2'b01;
        do op = 5'($urandom); while (op == OP_JAL);
      end
      K_JAL: begin ty = 2'b01; op = OP_JAL; end
      default: begin ty = 2'b11; op = 5'($urandom); end
    endcase
  endtask

  // Expected cycle-by-cycle trace of one instruction, from the stage rules.
  task automatic build_model(input int k, input logic zero, input logic stop,
                             input int fwait, input int mwait);
    q.delete();
    for (int i = 0; i < fwait; i++) push(3'd0, mk(1,0,0,0,0,0,2'b00), 1'b0, 1'b0);
    push(3'd0, mk(1,1,0,0,0,0,2'b00), 1'b1, 1'b0);
    if (stop) begin
      push(3'd1, mk(0,0,0,0,0,0,2'b00), 1'b0, 1'b0);
      return;
    end
    if (k == K_J) begin
      push(3'd1, mk(0,0,0,0,0,1,2'b10), 1'b0, 1'b0);
      return;
    end
    push(3'd1, mk(0,0,0,0,0,0,2'b00), 1'b0, 1'b0);
    case (k)
      K_BEQ: push(3'd2, mk(0,0,0,0,0,1, zero ? 2'b01 : 2'b11), 1'b0, 1'b0);
      K_NOP: push(3'd2, mk(0,0,0,0,0,1,2'b11), 1'b0, 1'b0);
      K_SW: begin
        push(3'd2, mk(0,0,0,0,0,0,2'b00), 1'b0, 1'b0);
        for (int i = 0; i < mwait; i++) push(3'd3, mk(0,0,1,1,0,0,2'b00), 1'b0, 1'b0);
        push(3'd3, mk(0,0,1,1,0,1,2'b11), 1'b0, 1'b1);
      end
      K_LW: begin
        push(3'd2, mk(0,0,0,0,0,0,2'b00), 1'b0, 1'b0);
        for (int i = 0; i < mwait; i++) push(3'd3, mk(0,0,1,0,0,0,2'b00), 1'b0, 1'b0);
        push(3'd3, mk(0,0,1,0,0,0,2'b00), 1'b0, 1'b1);
        push(3'd4, mk(0,0,0,0,1,1,2'b11), 1'b0, 1'b0);
      end
      default: begin
        push(3'd2, mk(0,0,0,0,0,0,2'b00), 1'b0, 1'b0);
        push(3'd4, mk(0,0,0,0,1,1, (k == K_JAL) ? 2'b10 : 2'b11), 1'b0, 1'b0);
      end
    endcase
  endtask

  // Entered and left at a falling edge, with the DUT expected in FETCH on entry.
  task automatic run_instr(input string tag, input int k, input logic zero, input logic stop,
                           input int fwait, input int mwait, input int abort_at);
    logic [1:0] ty;
    logic [4:0] op;
    logic [8:0] act;
    pick(k, ty, op);
    build_model(k, zero, stop, fwait, mwait);
    Type = ty;
    OPCode = op;
    for (int i = 0; i < q.size(); i++) begin
      if (abort_at >= 0 && i == abort_at) return;
      imem_ready = (q[i].st == 3'd0) ? q[i].irdy : 1'($urandom);
      dmem_ready = (q[i].st == 3'd3) ? q[i].drdy : 1'($urandom);
      Zero       = (q[i].st == 3'd2) ? zero : 1'($urandom);
      Stop       = (q[i].st == 3'd1) ? stop : 1'($urandom);
      #1;
      act = {halted, imem_req, IRWrite, dmem_req, dmem_we, RegWrite, PcWrite, PcSrc};
      n_cmp++;
      if (state !== q[i].st || act !== q[i].outs) begin
        n_bad++;
        $display("FAIL %s cycle %0d: state=%0d outs=%b, expected state=%0d outs=%b",
                 tag, i, state, act, q[i].st, q[i].outs);
      end
      @(negedge clk);
    end
    if (!stop && exp_retired < 65535) exp_retired++;
    n_cmp++;
    if (retired_count !== (CNT_EN ? 16'(exp_retired) : 16'h0000)) begin
      n_bad++;
      $display("FAIL %s retired_count: got %0d, expected %0d", tag, retired_count,
               CNT_EN ? exp_retired : 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    Stop = 1'($urandom);
    Zero = 1'($urandom);
    #1;
    n_cmp++;
    if ({imem_req, IRWrite, dmem_req, dmem_we, RegWrite, PcWrite, PcSrc} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b, expected 00000000",
               {imem_req, IRWrite, dmem_req, dmem_we, RegWrite, PcWrite, PcSrc});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (state !== 3'd0 || halted !== 1'b0 || retired_count !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_state: state=%0d halted=%b count=%0d, expected 0/0/0",
               state, halted, retired_count);
    end
    n_cmp++;
    if ({imem_req, IRWrite, dmem_req, dmem_we, RegWrite, PcWrite, PcSrc} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_strobes_after_edge: got %b, expected 00000000",
               {imem_req, IRWrite, dmem_req, dmem_we, RegWrite, PcWrite, PcSrc});
    end
    exp_retired = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    run_instr("rtype", K_R, 1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", K_BEQ, 1'b1, 1'b0, 0, 0, -1);
    run_instr("beq_not_taken", K_BEQ, 1'b0, 1'b0, 1, 0, -1);
  endtask

  task automatic test_mem();
    run_instr("lw_wait3", K_LW, 1'b0, 1'b0, 0, 3, -1);
    run_instr("sw_wait2", K_SW, 1'b0, 1'b0, 2, 2, -1);
  endtask

  task automatic test_jumps();
    run_instr("j", K_J, 1'b0, 1'b0, 0, 0, -1);
    run_instr("jal", K_JAL, 1'b0, 1'b0, 0, 0, -1);
    run_instr("nop_rsvd", K_NOP, 1'b0, 1'b0, 0, 0, -1);
    run_instr("itype_alu", K_I, 1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      run_instr("random", int'($urandom_range(7, 0)), 1'($urandom), 1'b0,
                int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), -1);
    end
  endtask

  task automatic test_retire_count();
    test_reset();
    for (int n = 0; n < 5; n++) begin
      run_instr("retire5", int'($urandom_range(7, 0)), 1'($urandom), 1'b0,
                int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), -1);
    end
    n_cmp++;
    if (retired_count !== (CNT_EN ? 16'd5 : 16'd0)) begin
      n_bad++;
      $display("FAIL retire5_total: got %0d, expected %0d", retired_count, CNT_EN ? 5 : 0);
    end
  endtask

  task automatic test_halt();
    run_instr("stop_decode", int'($urandom_range(7, 0)), 1'b0, 1'b1, 1, 0, -1);
    for (int c = 0; c < 10; c++) begin
      Type = 2'($urandom);
      OPCode = 5'($urandom);
      Zero = 1'($urandom);
      Stop = 1'($urandom);
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      #1;
      n_cmp++;
      if (state !== 3'd5 || {halted, imem_req, IRWrite, dmem_req, dmem_we, RegWrite, PcWrite, PcSrc} !== 9'h100) begin
        n_bad++;
        $display("FAIL halt_cycle%0d: state=%0d outs=%b, expected state=5 outs=100000000", c,
                 state, {halted, imem_req, IRWrite, dmem_req, dmem_we, RegWrite, PcWrite, PcSrc});
      end
      @(negedge clk);
    end
    test_reset();
  endtask

  task automatic test_reset_mid_mem();
    run_instr("pre_abort", K_R, 1'b0, 1'b0, 0, 0, -1);
    run_instr("lw_abort", K_LW, 1'b0, 1'b0, 0, 6, 5);
    n_cmp++;
    if (state !== 3'd3 || dmem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_in_mem: state=%0d dmem_req=%b, expected state=3 dmem_req=1",
               state, dmem_req);
    end
    test_reset();
    run_instr("after_abort", K_SW, 1'b0, 1'b0, 0, 1, -1);
  endtask

  initial begin
    reset = 1'b1;
    Type = 2'b00;
    OPCode = 5'd0;
    Zero = 1'b0;
    Stop = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_beq();
    test_mem();
    test_jumps();
    test_back_to_back();
    test_retire_count();
    test_halt();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
